// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard-controlled pipeline registers.
package hazard_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned CTRL_W_DFLT = 8;

  // Bit positions inside the packed decode control bundle
  localparam int unsigned CTRL_REGWRITE_BIT = 7;
  localparam int unsigned CTRL_MEMTOREG_BIT = 6;
  localparam int unsigned CTRL_MEMWRITE_BIT = 5;
  localparam int unsigned CTRL_BRANCH_BIT   = 4;
  localparam int unsigned CTRL_ALUSRC_BIT   = 3;
  localparam int unsigned CTRL_ALUCTRL_MSB  = 2;
  localparam int unsigned CTRL_ALUCTRL_LSB  = 0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Width-parameterised pipeline register: synchronous active-low reset,
// clear (bubble) dominating enable, separate reset and clear values.
module pipe_reg_en_clr
  import hazard_pkg::*;
#(
  parameter int unsigned   W       = 32,
  parameter logic [W-1:0]  RST_VAL = '0,
  parameter logic [W-1:0]  CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (clr)     state_d = CLR_VAL;
    else if (en) state_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RST_VAL;
    else        state_q <= state_d;
  end

  assign q = state_q;

endmodule

// File: rtl/hazard_pipe_regs.sv
// PC, IF/ID and ID/EX registers under stall/flush control, with stall-run
// tracking and a sticky protocol-error flag. Define HAZARD_PERF_CNT_EN to add
// the StallCycles/FlushCount performance counters.
module hazard_pipe_regs
  import hazard_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     CTRL_W   = CTRL_W_DFLT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     RUN_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 FlushE,
  input  logic [XLEN-1:0]      PCNextF,
  input  logic [31:0]          InstrF,
  input  logic [CTRL_W-1:0]    CtrlD,
  input  logic [REG_IDX_W-1:0] RS1D,
  input  logic [REG_IDX_W-1:0] RS2D,
  input  logic [REG_IDX_W-1:0] RdD,
  output logic [XLEN-1:0]      PCF,
  output logic [31:0]          InstrD,
  output logic [XLEN-1:0]      PCD,
  output logic                 ValidD,
  output logic [CTRL_W-1:0]    CtrlE,
  output logic [REG_IDX_W-1:0] RS1E,
  output logic [REG_IDX_W-1:0] RS2E,
  output logic [REG_IDX_W-1:0] RdE,
  output logic                 ValidE,
  output logic [RUN_W-1:0]     StallRun,
  output logic [RUN_W-1:0]     MaxStallRun,
  output logic                 ProtoErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          StallCycles,
  output logic [31:0]          FlushCount
`endif
);

  localparam int unsigned IFID_W = 1 + XLEN + 32;
  localparam int unsigned IDEX_W = 1 + CTRL_W + 3 * REG_IDX_W;
  localparam logic [IFID_W-1:0] IFID_EMPTY = {1'b0, {XLEN{1'b0}}, NOP_INSTR};
  localparam logic [RUN_W-1:0]  RUN_MAX    = '1;

  logic [XLEN-1:0]   pc_q;
  logic [IFID_W-1:0] ifid_q;
  logic [IDEX_W-1:0] idex_q;

  pipe_reg_en_clr #(
    .W       (XLEN),
    .RST_VAL (RESET_PC),
    .CLR_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!StallF),
    .clr   (1'b0),
    .d     (PCNextF),
    .q     (pc_q)
  );

  pipe_reg_en_clr #(
    .W       (IFID_W),
    .RST_VAL (IFID_EMPTY),
    .CLR_VAL (IFID_EMPTY)
  ) u_ifid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!StallD),
    .clr   (FlushD),
    .d     ({1'b1, pc_q, InstrF}),
    .q     (ifid_q)
  );

  // Execute has no stall: it always loads unless bubbled by FlushE
  pipe_reg_en_clr #(
    .W       (IDEX_W),
    .RST_VAL ('0),
    .CLR_VAL ('0)
  ) u_idex_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (FlushE),
    .d     ({ifid_q[IFID_W-1], CtrlD, RS1D, RS2D, RdD}),
    .q     (idex_q)
  );

  assign PCF                        = pc_q;
  assign {ValidD, PCD, InstrD}      = ifid_q;
  assign {ValidE, CtrlE, RS1E, RS2E, RdE} = idex_q;

  logic [RUN_W-1:0] stall_run_q, stall_run_d;
  logic [RUN_W-1:0] max_run_q, max_run_d;
  logic             proto_err_q, proto_err_d;
  logic [RUN_W-1:0] run_inc;

  always_comb begin
    run_inc     = (stall_run_q == RUN_MAX) ? RUN_MAX : stall_run_q + 1'b1;
    stall_run_d = StallD ? run_inc : '0;
    max_run_d   = max_run_q;
    if (StallD && (run_inc > max_run_q)) max_run_d = run_inc;
    // Held decode needs both a held fetch and a bubbled execute
    proto_err_d = proto_err_q | (StallD & (!StallF | !FlushE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_run_q <= '0;
      max_run_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      stall_run_q <= stall_run_d;
      max_run_q   <= max_run_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign StallRun    = stall_run_q;
  assign MaxStallRun = max_run_q;
  assign ProtoErr    = proto_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + (StallD ? 32'd1 : 32'd0);
    flush_count_d  = flush_count_q + ((FlushD | FlushE) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`endif

endmodule

// File: doc/hazard_pipe_regs.md
Name: hazard_pipe_regs

Overview:
- Consumer end of the hazard-control interface. Holds the PC register, the IF/ID register and the ID/EX register, and obeys StallF/StallD/FlushD/FlushE from the stall unit and branch-resolution logic.
- Injects bubbles on flush, freezes stages on stall, and tracks stall-run length and protocol violations.
- Sits between fetch/decode datapath and the execute stage of the 5-stage core.

Parameters:
- XLEN, 32, datapath/PC width.
- CTRL_W, 8, width of the packed decode control bundle (RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUCtrl[2:0]).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RUN_W, 6, width of the stall-run counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- StallF  in  1  hold PC register.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  bubble IF/ID (taken branch).
- FlushE  in  1  bubble ID/EX.
- PCNextF  in  XLEN  next PC from PC mux.
- InstrF  in  32  fetched instruction.
- CtrlD  in  CTRL_W  decoded control bundle.
- RS1D, RS2D, RdD  in  5 each  decoded register indices.
- PCF  out  XLEN  current fetch PC.
- InstrD, PCD  out  32 / XLEN  decode-stage instruction and PC.
- ValidD  out  1  decode slot holds a real instruction.
- CtrlE  out  CTRL_W  execute-stage control.
- RS1E, RS2E, RdE  out  5 each  execute-stage register indices.
- ValidE  out  1  execute slot holds a real instruction.
- StallRun  out  RUN_W  length of the current consecutive-stall run; saturating.
- MaxStallRun  out  RUN_W  longest run since reset; saturating.
- ProtoErr  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_n=0 at clk edge) sets these values:
  - PCF=RESET_PC
  - InstrD=32'h0000_0013 (NOP), PCD=0, ValidD=0
  - CtrlE=0, RS1E=RS2E=RdE=0, ValidE=0
  - StallRun=0, MaxStallRun=0, ProtoErr=0
- Reset overrides every other input in the same cycle. Reset asserted mid-stall clears the run counters and any pending hold.
- PC register: if !StallF then PCF<=PCNextF, else hold. One-cycle latency.
- IF/ID register, in priority order:
  - FlushD: InstrD<=NOP, PCD<=0, ValidD<=0. Flush dominates even when StallD=1.
  - else StallD: hold all fields.
  - else load InstrF, PCF, ValidD<=1.
- ID/EX register:
  - FlushE: CtrlE<=0, RS1E/RS2E/RdE<=0, ValidE<=0.
  - else load CtrlD, RS1D, RS2D, RdD, and ValidE<=ValidD.
  - No stall input on E; a bubble from FlushE has all-zero control, so no RegWrite and no MemWrite.
- Stall-run counters:
  - StallRun increments each cycle StallD=1, saturating at 2^RUN_W-1, and clears to 0 on the first cycle StallD=0.
  - MaxStallRun <= max(MaxStallRun, StallRun+1) while stalling, saturating.
- Protocol checks set ProtoErr=1 and hold it until reset:
  - StallD=1 with StallF=0: fetch advancing under a held decode drops an instruction.
  - StallD=1 with FlushE=0: the stalled instruction would be duplicated into EX.
- The block continues to obey its inputs after ProtoErr is set and performs no corrective action.
- No combinational paths from inputs to outputs; every output is a flop.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs StallCycles[31:0] and FlushCount[31:0], both wrapping modulo 2^32 and reset to 0.
  - StallCycles counts cycles with StallD=1.
  - FlushCount counts cycles with FlushD=1, FlushE=1, or both; a cycle with both counts once.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package `hazard_pkg` holds:
  - NOP_INSTR = 32'h0000_0013
  - REG_IDX_W = 5
  - CTRL_W default
  - bit positions of each field in the control bundle
- One natural sub-module `pipe_reg_en_clr`, a width-parameterised flop with enable, clear, and reset value. It is instantiated for the PC, IF/ID and ID/EX registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with StallF=1, FlushD=1 → PCF=RESET_PC, InstrD=0x00000013, ValidD=0, ValidE=0, ProtoErr=0.
- Stream: PCNextF=4,8,12 with no stalls → PCF follows one cycle later; PCD lags PCF by one cycle; ValidE=1 from the third edge.
- Load-use: StallF=StallD=FlushE=1 for 1 cycle with InstrD=0x00A00093 → InstrD and PCF hold, CtrlE=0 and ValidE=0 next cycle, StallRun=1, then 0 after release.
- FlushD with StallD both 1 → InstrD=NOP, ValidD=0; flush dominates.
- Run saturation: RUN_W=6, stall 70 consecutive cycles with StallF=StallD=FlushE=1 → StallRun=63 and MaxStallRun=63, ProtoErr stays 0.
- Violation: StallD=1, StallF=0 for one cycle → ProtoErr=1 and remains 1 until reset. With HAZARD_PERF_CNT_EN, 3 stall cycles plus 2 flush cycles → StallCycles=3, FlushCount=2.
